// File: rtl/dft_bist_harness.sv
// BIST initiator for the streaming DFT core: LFSR frames out, MISR-compacted
// Y stream in, final signature compared against golden_sig.
module dft_bist_harness #(
    parameter int          FRAME_CYCLES = 16,
    parameter int          NUM_FRAMES   = 30,
    parameter int          TIMEOUT      = 500,
    parameter logic [63:0] SEED         = 64'h0123_4567_89AB_CDEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] golden_sig,
    output logic        next,
    output logic [15:0] X0,
    output logic [15:0] X1,
    output logic [15:0] X2,
    output logic [15:0] X3,
    input  logic        next_out,
    input  logic [15:0] Y0,
    input  logic [15:0] Y1,
    input  logic [15:0] Y2,
    input  logic [15:0] Y3,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [63:0] signature
);

    localparam int MAXC = (TIMEOUT > FRAME_CYCLES) ? TIMEOUT : FRAME_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int FW   = $clog2(NUM_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_CAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [63:0]   lfsr_q, lfsr_d;
    logic [63:0]   misr_q, misr_d;
    logic [63:0]   x_q, x_d;
    logic          next_q, next_d;
    logic          pass_q, pass_d;
    logic          tout_q, tout_d;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        pass_d  = pass_q;
        tout_d  = tout_q;
        next_d  = 1'b0;
        x_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_d  = SEED;
                    misr_d  = '0;
                    pass_d  = 1'b0;
                    tout_d  = 1'b0;
                    frame_d = '0;
                    cnt_d   = '0;
                    next_d  = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // x_q lags one cycle, so data shows on SEND cycles 1..FRAME_CYCLES
                if (cnt_q == CW'(FRAME_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    x_d    = lfsr_q;
                    lfsr_d = lfsr_step(lfsr_q);
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (next_out) begin
                    cnt_d   = '0;
                    state_d = S_CAP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAP: begin
                misr_d = lfsr_step(misr_q) ^ {Y0, Y1, Y2, Y3};
                if (cnt_q == CW'(FRAME_CYCLES - 1)) begin
                    cnt_d   = '0;
                    frame_d = frame_q + FW'(1);
                    if (frame_d == FW'(NUM_FRAMES)) begin
                        pass_d  = (misr_d == golden_sig) && !tout_q;
                        state_d = S_DONE;
                    end else begin
                        next_d  = 1'b1;
                        state_d = S_SEND;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            lfsr_q  <= SEED;
            misr_q  <= '0;
            x_q     <= '0;
            next_q  <= 1'b0;
            pass_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            x_q     <= x_d;
            next_q  <= next_d;
            pass_q  <= pass_d;
            tout_q  <= tout_d;
        end
    end

    assign next        = next_q;
    assign X0          = x_q[63:48];
    assign X1          = x_q[47:32];
    assign X2          = x_q[31:16];
    assign X3          = x_q[15:0];
    assign busy        = (state_q == S_SEND) || (state_q == S_WAIT) ||
                         (state_q == S_CAP);
    assign done        = (state_q == S_DONE);
    assign pass        = pass_q;
    assign timeout_err = tout_q;
    assign signature   = misr_q;

endmodule

// File: tb/tb_dft_bist_harness.sv
// Scoreboard bench for dft_bist_harness with a configurable delay-line DFT stub.
module tb_dft_bist_harness;

    localparam int          FC     = 16;
    localparam int          NF     = 4;
    localparam logic [63:0] SEED   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] KEYBAD = 64'h0001_0000_0000_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] golden;
    logic        next;
    logic [15:0] X0, X1, X2, X3;
    logic        next_out;
    logic [15:0] Y0, Y1, Y2, Y3;
    logic        busy;
    logic        done;
    logic        pass;
    logic        tout;
    logic [63:0] sig;

    dft_bist_harness #(
        .FRAME_CYCLES(FC),
        .NUM_FRAMES  (NF),
        .TIMEOUT     (500),
        .SEED        (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .golden_sig (golden),
        .next       (next),
        .X0         (X0),
        .X1         (X1),
        .X2         (X2),
        .X3         (X3),
        .next_out   (next_out),
        .Y0         (Y0),
        .Y1         (Y1),
        .Y2         (Y2),
        .Y3         (Y3),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .timeout_err(tout),
        .signature  (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stub modes: 0 loopback (Y = X ^ key), 1 zero Y, 2 never answers
    int          mode;
    int          dly;
    logic [63:0] key;
    logic [99:0] npipe;
    logic [63:0] ypipe [100];
    logic [63:0] y_w;

    always @(posedge clk) begin
        if (rst) npipe <= '0;
        else     npipe <= {npipe[98:0], next};
        ypipe[0] <= {X0, X1, X2, X3};
        for (int i = 1; i < 100; i++) ypipe[i] <= ypipe[i-1];
    end

    assign next_out = (mode == 2) ? 1'b0 : npipe[dly-1];
    assign y_w      = (mode == 1) ? 64'h0 : (ypipe[dly-1] ^ key);
    assign Y0 = y_w[63:48];
    assign Y1 = y_w[47:32];
    assign Y2 = y_w[31:16];
    assign Y3 = y_w[15:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int nxt_cyc = -1000;

    typedef struct {
        logic [63:0] sig;
        logic        pass;
        logic        tout;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] expx_q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [63:0] lstep(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    function automatic logic [63:0] ref_sig(input logic [63:0] k);
        logic [63:0] l = SEED;
        logic [63:0] m = 64'h0;
        for (int i = 0; i < NF * FC; i++) begin
            m = lstep(m) ^ (l ^ k);
            l = lstep(l);
        end
        return m;
    endfunction

    // monitor: X words of the first frame and every done pulse
    always @(negedge clk) begin
        if (next) begin
            nxt_cyc = cyc;
        end else if (expx_q.size() > 0 &&
                     (cyc == nxt_cyc + 1 || cyc == nxt_cyc + 2)) begin
            chk("x_word", {X0, X1, X2, X3}, expx_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_sig", sig, e.sig);
                chk("done_pass", 64'(pass), 64'(e.pass));
                chk("done_tout", 64'(tout), 64'(e.tout));
                chk("done_busy", 64'(busy), 64'h0);
                if (e.lat > 0)
                    chk("done_latency", 64'(cyc - nxt_cyc), 64'(e.lat));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run(input logic [63:0] g, input logic [63:0] esig,
                       input logic epass, input logic etout,
                       input bit chkx, input int lat, input bit midstart);
        int d0;
        bit seen;
        exp_t e;
        e.sig  = esig;
        e.pass = epass;
        e.tout = etout;
        e.lat  = lat;
        exp_q.push_back(e);
        if (chkx) begin
            expx_q.push_back(64'h0123_4567_89AB_CDEF);
            expx_q.push_back(64'hD891_A2B3_C4D5_E6F7);
        end
        golden = g;
        d0 = done_cnt;
        pulse_start();
        if (midstart) begin
            repeat (40) @(negedge clk);
            pulse_start();
        end
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'h1);
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'h0);
    endtask

    logic [63:0] ref_ok;
    logic [63:0] ref_bad;

    initial begin
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        golden = 64'h0;
        mode   = 0;
        dly    = 20;
        key    = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_pass", 64'(pass), 64'h0);
        chk("rst_tout", 64'(tout), 64'h0);
        chk("rst_sig", sig, 64'h0);
        chk("rst_next", 64'(next), 64'h0);
        chk("rst_x", {X0, X1, X2, X3}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        ref_ok  = ref_sig(64'h0);
        ref_bad = ref_sig(KEYBAD);

        mode = 1; dly = 100;
        run(64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 0, 1'b0);

        mode = 0; dly = 20;
        run(ref_ok, ref_ok, 1'b1, 1'b0, 1'b1, 0, 1'b1);
        run(ref_ok ^ (64'h1 << 17), ref_ok, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        key = KEYBAD;
        run(ref_ok, ref_bad, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("sig_hold_idle", sig, ref_bad);
        key = 64'h0;

        mode = 2;
        run(64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 517, 1'b0);
        mode = 0;

        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'h0);
        chk("rst_clears_tout", 64'(tout), 64'h0);
        @(negedge clk);
        chk("rst_start_busy2", 64'(busy), 64'h0);
        repeat (30) @(negedge clk);

        golden = ref_ok;
        pulse_start();
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (next) n++;
            if (n == 4) break;
            @(negedge clk);
        end
        chk("mid_frames", 64'(n), 64'd4);
        repeat (26) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_sig", sig, 64'h0);
        chk("mid_rst_next", 64'(next), 64'h0);
        repeat (30) @(negedge clk);
        run(ref_ok, ref_ok, 1'b1, 1'b0, 1'b1, 0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size() + expx_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
